sprite_line_scanner: RTL and testbench

Sequential, parametrised successor to the single-register sprite/pixel comparator. During horizontal blanking it walks the sprite register bank and collects up to `MAX_ACTIVE` sprites that intersect the next scan line. During the visible line it answers per-pixel hit queries against that list with fixed priority. It sits between the sprite register bank and the pixel pipeline of the video controller.

---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_slot_match.sv | 30 +++
 rtl/sprite_line_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_sprite_line_scanner.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, slot record and scan FSM encoding for the sprite line scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    // Status field of a sprite register; only SPR_ACTIVE marks a displayable sprite.
    localparam int          SPR_STATUS_HI = 31;
    localparam int          SPR_STATUS_LO = 29;
    localparam logic [2:0]  SPR_ACTIVE    = 3'b001;

    // Default field placement and widths of the sprite register layout.
    localparam int SPR_X_LSB   = 19;
    localparam int SPR_Y_LSB   = 9;
    localparam int SPR_COORD_W = 10;
    localparam int SPR_ID_W    = 5;

    // One entry of the per-line sprite list: register index, left x, row within sprite.
    typedef struct packed {
        logic [SPR_ID_W-1:0]    id;
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] row;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/sprite_slot_match.sv
// Horizontal range check of one display slot against the queried pixel x.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sprite_slot_match
    import sprite_pkg::*;
#(
    parameter int COORD_W     = SPR_COORD_W,
    parameter int SPRITE_SIZE = 20
) (
    input  logic               en,
    input  logic [COORD_W-1:0] slot_x,
    input  logic [COORD_W-1:0] pixel_x,
    output logic               match,
    output logic [COORD_W-1:0] col
);

    localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(SPRITE_SIZE);

    // One extra bit so sprites near the right edge do not wrap back to x=0.
    logic [COORD_W:0] x_lo;
    logic [COORD_W:0] x_hi;
    logic [COORD_W:0] px;

    assign x_lo  = {1'b0, slot_x};
    assign x_hi  = x_lo + SIZE_EXT;
    assign px    = {1'b0, pixel_x};
    assign match = en && (px >= x_lo) && (px < x_hi);
    assign col   = pixel_x - slot_x;

endmodule

// File: rtl/sprite_line_scanner.sv
// Builds the next line's sprite list during blanking and answers per-pixel hit queries.
// Latency: scan_done NUM_SPRITES+2 cycles after scan_start; query result 1 cycle after pixel_valid.
// Backpressure: none; scan_start outside IDLE is ignored, one query accepted every cycle.
// Optional sticky overflow flag: define SPRITE_OVERFLOW_EN.
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int REG_W       = 32,
    parameter int NUM_SPRITES = 32,
    parameter int MAX_ACTIVE  = 4,
    parameter int COORD_W     = SPR_COORD_W,
    parameter int X_LSB       = SPR_X_LSB,
    parameter int Y_LSB       = SPR_Y_LSB,
    parameter int SPRITE_SIZE = 20,
    localparam int AW         = $clog2(NUM_SPRITES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_start,
    input  logic [COORD_W-1:0] scan_line,
    output logic               reg_rd,
    output logic [AW-1:0]      reg_addr,
    input  logic [REG_W-1:0]   reg_data,
    output logic               scan_busy,
    output logic               scan_done,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] pixel_x,
    output logic               hit,
    output logic [AW-1:0]      hit_id,
    output logic [COORD_W-1:0] hit_col,
    output logic [COORD_W-1:0] hit_row,
    output logic               overflow
);

    localparam int               CNT_W     = $clog2(MAX_ACTIVE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_ACTIVE);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(NUM_SPRITES - 1);
    localparam logic [COORD_W:0] SIZE_EXT  = (COORD_W+1)'(SPRITE_SIZE);

    // Slot records are sized by the package; a wider bank or coordinate cannot be stored.
    if (AW > SPR_ID_W || COORD_W > SPR_COORD_W) begin : g_width_check
        $error("sprite_line_scanner: AW/COORD_W exceed slot_t field widths");
    end

    scan_state_t        state;
    logic [COORD_W-1:0] line_q;
    logic               start_accept;

    assign start_accept = (state == ST_IDLE) && scan_start;

    // Scan sequencer: walks every bank address once, then drains and swaps the list.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            reg_rd    <= 1'b0;
            reg_addr  <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            line_q    <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        line_q    <= scan_line;
                        reg_rd    <= 1'b1;
                        reg_addr  <= '0;
                        scan_busy <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (reg_addr == LAST_ADDR) begin
                        reg_rd   <= 1'b0;
                        reg_addr <= '0;
                        state    <= ST_DRAIN;
                    end else begin
                        reg_addr <= reg_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    scan_done <= 1'b1;
                    state     <= ST_SWAP;
                end
                ST_SWAP: begin
                    scan_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // reg_data answers the read issued one cycle earlier; remember which index it belongs to.
    logic          eval_vld;
    logic [AW-1:0] eval_id;

    // Align the read index with the returning bank word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eval_vld <= 1'b0;
            eval_id  <= '0;
        end else begin
            eval_vld <= reg_rd;
            eval_id  <= reg_addr;
        end
    end

    logic [2:0]         spr_status;
    logic [COORD_W-1:0] spr_x;
    logic [COORD_W-1:0] spr_y;
    logic [COORD_W:0]   line_ext;
    logic [COORD_W:0]   y_lo;
    logic [COORD_W:0]   y_hi;
    logic               eval_match;
    logic [COORD_W-1:0] eval_row;
    slot_t              new_slot;
    logic               unused_data;

    assign spr_status = reg_data[SPR_STATUS_HI:SPR_STATUS_LO];
    assign spr_x      = reg_data[X_LSB +: COORD_W];
    assign spr_y      = reg_data[Y_LSB +: COORD_W];
    assign line_ext   = {1'b0, line_q};
    assign y_lo       = {1'b0, spr_y};
    assign y_hi       = y_lo + SIZE_EXT;
    assign eval_match = eval_vld && (spr_status == SPR_ACTIVE)
                        && (line_ext >= y_lo) && (line_ext < y_hi);
    assign eval_row   = line_q - spr_y;
    assign unused_data = ^reg_data;

    // Assemble the slot record for the sprite currently being evaluated.
    always_comb begin
        new_slot     = '0;
        new_slot.id  = SPR_ID_W'(eval_id);
        new_slot.x   = SPR_COORD_W'(spr_x);
        new_slot.row = SPR_COORD_W'(eval_row);
    end

    slot_t            shadow_list [MAX_ACTIVE];
    slot_t            disp_list   [MAX_ACTIVE];
    logic [CNT_W-1:0] shadow_cnt;
    logic [CNT_W-1:0] disp_cnt;

    // Shadow list fills in ascending index order; the display list only changes on swap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_cnt <= '0;
            disp_cnt   <= '0;
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                shadow_list[i] <= '0;
                disp_list[i]   <= '0;
            end
        end else begin
            if (start_accept) begin
                shadow_cnt <= '0;
            end else if (eval_match && (shadow_cnt < CNT_MAX)) begin
                for (int i = 0; i < MAX_ACTIVE; i++) begin
                    if (shadow_cnt == CNT_W'(i)) begin
                        shadow_list[i] <= new_slot;
                    end
                end
                shadow_cnt <= shadow_cnt + CNT_W'(1);
            end
            if (state == ST_SWAP) begin
                disp_list <= shadow_list;
                disp_cnt  <= shadow_cnt;
            end
        end
    end

`ifdef SPRITE_OVERFLOW_EN
    logic ovf_q;

    // Sticky until the next accepted scan: a matching sprite found the list already full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (start_accept) begin
            ovf_q <= 1'b0;
        end else if (eval_match && (shadow_cnt == CNT_MAX)) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    logic               slot_hit [MAX_ACTIVE];
    logic [COORD_W-1:0] slot_col [MAX_ACTIVE];

    for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_slot
        sprite_slot_match #(
            .COORD_W     (COORD_W),
            .SPRITE_SIZE (SPRITE_SIZE)
        ) u_match (
            .en      (disp_cnt > CNT_W'(g)),
            .slot_x  (disp_list[g].x[COORD_W-1:0]),
            .pixel_x (pixel_x),
            .match   (slot_hit[g]),
            .col     (slot_col[g])
        );
    end

    logic               sel_hit;
    logic [AW-1:0]      sel_id;
    logic [COORD_W-1:0] sel_col;
    logic [COORD_W-1:0] sel_row;

    // Fixed priority: scanning down to slot 0 leaves the lowest matching slot selected.
    always_comb begin
        sel_hit = 1'b0;
        sel_id  = '0;
        sel_col = '0;
        sel_row = '0;
        for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                sel_hit = 1'b1;
                sel_id  = disp_list[i].id[AW-1:0];
                sel_col = slot_col[i];
                sel_row = disp_list[i].row[COORD_W-1:0];
            end
        end
    end

    // Register the query answer; everything reads 0 without a query or without a hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit     <= 1'b0;
            hit_id  <= '0;
            hit_col <= '0;
            hit_row <= '0;
        end else if (pixel_valid && sel_hit) begin
            hit     <= 1'b1;
            hit_id  <= sel_id;
            hit_col <= sel_col;
            hit_row <= sel_row;
        end else begin
            hit     <= 1'b0;
            hit_id  <= '0;
            hit_col <= '0;
            hit_row <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner with a query scoreboard and a register-bank model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sprite_line_scanner;

    localparam int NS = 32;
`ifdef SPRITE_OVERFLOW_EN
    localparam int EXP_OVF = 1;
`else
    localparam int EXP_OVF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_start = 1'b0;
    logic [9:0]  scan_line = '0;
    logic        reg_rd;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data = '0;
    logic        scan_busy;
    logic        scan_done;
    logic        pixel_valid = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic        hit;
    logic [4:0]  hit_id;
    logic [9:0]  hit_col;
    logic [9:0]  hit_row;
    logic        overflow;

    always #5 clk = ~clk;

    sprite_line_scanner dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scan_start  (scan_start),
        .scan_line   (scan_line),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .hit         (hit),
        .hit_id      (hit_id),
        .hit_col     (hit_col),
        .hit_row     (hit_row),
        .overflow    (overflow)
    );

    // Register bank: read data returns one cycle after the strobe.
    logic [31:0] bank [NS];
    always @(posedge clk) if (reg_rd) reg_data <= bank[reg_addr];

    typedef struct {
        logic       h;
        logic [4:0] id;
        logic [9:0] col;
        logic [9:0] row;
        int         tag;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   ntag  = 0;
    logic qv_d  = 1'b0;

    always @(posedge clk) qv_d <= pixel_valid;

    // Monitor: every answered query is popped and compared; idle cycles must show no hit.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (qv_d) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_answer: got hit=%0d id=%0d, no query pending", hit, hit_id);
                end else begin
                    e = expq.pop_front();
                    if ({hit, hit_id, hit_col, hit_row} !== {e.h, e.id, e.col, e.row}) begin
                        fails++;
                        $display("FAIL query%0d: got hit=%0d id=%0d col=%0d row=%0d, expected hit=%0d id=%0d col=%0d row=%0d",
                                 e.tag, hit, hit_id, hit_col, hit_row, e.h, e.id, e.col, e.row);
                    end
                end
            end else begin
                tests++;
                if (hit !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_hit: got hit=%0d, expected 0", hit);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic push(input int h, input int id, input int col, input int row);
        exp_t e;
        e.h   = h[0];
        e.id  = id[4:0];
        e.col = col[9:0];
        e.row = row[9:0];
        e.tag = ntag;
        ntag++;
        expq.push_back(e);
    endtask

    // Issue one query at a negedge; returns at the next negedge with pixel_valid dropped.
    task automatic query(input int x, input int h, input int id, input int col, input int row);
        push(h, id, col, row);
        pixel_valid = 1'b1;
        pixel_x     = x[9:0];
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    function automatic logic [31:0] mk(input int st, input int x, input int y);
        logic [31:0] r;
        r        = '0;
        r[31:29] = st[2:0];
        r[28:19] = x[9:0];
        r[18:9]  = y[9:0];
        return r;
    endfunction

    task automatic clear_bank();
        for (int i = 0; i < NS; i++) bank[i] = '0;
    endtask

    // Start a scan at a negedge; reports cycles to scan_done and overflow one cycle after start.
    task automatic scan(input int line, output int lat, output int ovf1);
        scan_line  = line[9:0];
        scan_start = 1'b1;
        lat  = -1;
        ovf1 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                scan_start = 1'b0;
                ovf1 = int'(overflow);
            end
            if (scan_done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_reg_rd"},    int'(reg_rd),    0);
        chk({nm, "_reg_addr"},  int'(reg_addr),  0);
        chk({nm, "_scan_busy"}, int'(scan_busy), 0);
        chk({nm, "_scan_done"}, int'(scan_done), 0);
        chk({nm, "_hit"},       int'(hit),       0);
        chk({nm, "_hit_id"},    int'(hit_id),    0);
        chk({nm, "_hit_col"},   int'(hit_col),   0);
        chk({nm, "_hit_row"},   int'(hit_row),   0);
        chk({nm, "_overflow"},  int'(overflow),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int o1;
        int first;
        int ndone;
        int rc;
        clear_bank();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Line scan with two sprites on the line.
        clear_bank();
        bank[3] = mk(1, 150, 100);
        bank[7] = mk(1, 400, 110);
        scan(115, lat, o1);
        chk("scan_latency", lat, 34);
        @(negedge clk);
        chk("busy_after_swap", int'(scan_busy), 0);
        query(155, 1, 3, 5, 15);
        query(405, 1, 7, 5, 5);
        query(10, 0, 0, 0, 0);
        query(169, 1, 3, 19, 15);
        query(170, 0, 0, 0, 0);

        // Range boundaries and non-active status codes.
        clear_bank();
        bank[2] = mk(3, 600, 60);
        bank[4] = mk(1, 200, 50);
        bank[9] = mk(0, 500, 60);
        scan(69, lat, o1);
        chk("bound_latency", lat, 34);
        @(negedge clk);
        query(219, 1, 4, 19, 19);
        query(220, 0, 0, 0, 0);
        query(200, 1, 4, 0, 19);
        query(199, 0, 0, 0, 0);
        query(505, 0, 0, 0, 0);
        query(605, 0, 0, 0, 0);
        scan(70, lat, o1);
        @(negedge clk);
        query(210, 0, 0, 0, 0);
        scan(50, lat, o1);
        @(negedge clk);
        query(200, 1, 4, 0, 0);
        scan(49, lat, o1);
        @(negedge clk);
        query(200, 0, 0, 0, 0);

        // Overflow: six sprites on one line, four slots.
        clear_bank();
        for (int i = 0; i < 6; i++) bank[i] = mk(1, 50 * i, 5);
        scan(10, lat, o1);
        chk("ovf_latency", lat, 34);
        chk("ovf_flag", int'(overflow), EXP_OVF);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) query(50 * i + 1, 1, i, 1, 5);
            else       query(50 * i + 1, 0, 0, 0, 0);
        end
        scan(200, lat, o1);
        chk("ovf_clear_on_start", o1, 0);
        chk("ovf_after_empty_scan", int'(overflow), 0);
        @(negedge clk);

        // Priority between overlapping sprites.
        clear_bank();
        bank[2] = mk(1, 290, 0);
        bank[5] = mk(1, 295, 0);
        scan(3, lat, o1);
        @(negedge clk);
        query(300, 1, 2, 10, 3);
        query(312, 1, 5, 17, 3);
        query(289, 0, 0, 0, 0);

        // Queries during a scan see the old list; a second start mid-scan is ignored.
        clear_bank();
        bank[8] = mk(1, 600, 300);
        scan_line  = 10'd305;
        scan_start = 1'b1;
        first = -1;
        ndone = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            if (c == 1)  scan_start = 1'b0;
            if (c == 5)  begin push(1, 2, 10, 3); pixel_valid = 1'b1; pixel_x = 10'd300; end
            if (c == 6)  begin push(0, 0, 0, 0);  pixel_valid = 1'b1; pixel_x = 10'd605; end
            if (c == 10) begin scan_line = 10'd7; scan_start = 1'b1; end
            if (c == 11) scan_start = 1'b0;
            if (c == 20) chk("busy_mid_scan", int'(scan_busy), 1);
            if (scan_done) begin
                ndone++;
                if (first < 0) first = c;
            end
            if (c == 34) begin push(1, 2, 10, 3); pixel_valid = 1'b1; pixel_x = 10'd300; end
            if (c == 35) begin push(1, 8, 5, 5);  pixel_valid = 1'b1; pixel_x = 10'd605; end
            if (c == 36) begin push(0, 0, 0, 0);  pixel_valid = 1'b1; pixel_x = 10'd300; end
            if (c == 38) chk("busy_after_restart_ignored", int'(scan_busy), 0);
        end
        pixel_valid = 1'b0;
        chk("restart_done_cycle", first, 34);
        chk("restart_done_count", ndone, 1);

        // Reset in the middle of READ.
        scan_line  = 10'd305;
        scan_start = 1'b1;
        rc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) scan_start = 1'b0;
            if (reg_rd && reg_addr == 5'd12) begin
                rc = c;
                break;
            end
        end
        chk("reset_addr12_cycle", rc, 13);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midscan_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        query(605, 0, 0, 0, 0);
        query(300, 0, 0, 0, 0);
        scan(305, lat, o1);
        chk("post_reset_latency", lat, 34);
        @(negedge clk);
        query(605, 1, 8, 5, 5);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
